// File: rtl/k10_axil_master.sv
// rtl/k10_axil_master.sv - single-outstanding AXI4-Lite master behind a simple request/response port
//
// Ports:
//   i_clk, i_rst_n            rising-edge clock, asynchronous active-low reset
//   i_req_*  / o_req_ready    request channel (we, byte address, wdata, byte enables)
//   o_rsp_valid               one-cycle completion pulse, o_rsp_rdata / o_rsp_err held until next
//   o_busy                    a transaction is in flight
//   m_axi_*                   AXI4-Lite master (AW, W, B, AR, R channels)
module k10_axil_master #(
  parameter logic [2:0] AXI_PROT = 3'b000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [3:0]  i_req_be,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic        o_busy,
  output logic [31:0] m_axi_awaddr,
  output logic [2:0]  m_axi_awprot,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [31:0] m_axi_araddr,
  output logic [2:0]  m_axi_arprot,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready
);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  logic        we_q;
  logic        aw_done, w_done;
  logic        rsp_valid_q, rsp_err_q;
  logic [31:0] rsp_rdata_q;

  logic accept, aw_fire, w_fire, b_fire, r_fire;

  assign accept  = i_req_valid && o_req_ready;
  assign aw_fire = m_axi_awvalid && m_axi_awready;
  assign w_fire  = m_axi_wvalid && m_axi_wready;
  assign b_fire  = m_axi_bvalid && m_axi_bready;
  assign r_fire  = m_axi_rvalid && m_axi_rready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // All valids/readies decode from state (and the per-channel done flags),
  // so an asynchronous reset of the state register drops them immediately.
  always_comb begin
    state_nxt     = state;
    o_req_ready   = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    case (state)
      IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) state_nxt = i_req_we ? WR_ADDR_DATA : RD_ADDR;
      end
      WR_ADDR_DATA: begin
        m_axi_awvalid = !aw_done;
        m_axi_wvalid  = !w_done;
        // Leave once each channel has either already completed or completes now.
        if ((aw_done || m_axi_awready) && (w_done || m_axi_wready)) state_nxt = WR_RESP;
      end
      WR_RESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) state_nxt = IDLE;
      end
      RD_ADDR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_nxt = RD_DATA;
      end
      RD_DATA: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      we_q        <= 1'b0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (accept) begin
        addr_q  <= i_req_addr;
        wdata_q <= i_req_wdata;
        be_q    <= i_req_be;
        we_q    <= i_req_we;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (aw_fire) aw_done <= 1'b1;
        if (w_fire)  w_done  <= 1'b1;
      end
      if (b_fire || r_fire) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= we_q ? (m_axi_bresp != 2'b00) : (m_axi_rresp != 2'b00);
        rsp_rdata_q <= we_q ? 32'h0 : m_axi_rdata;
      end
    end
  end

  assign o_busy       = (state != IDLE);
  assign o_rsp_valid  = rsp_valid_q;
  assign o_rsp_err    = rsp_err_q;
  assign o_rsp_rdata  = rsp_rdata_q;
  assign m_axi_awaddr = addr_q;
  assign m_axi_araddr = addr_q;
  assign m_axi_wdata  = wdata_q;
  assign m_axi_wstrb  = be_q;
  assign m_axi_awprot = AXI_PROT;
  assign m_axi_arprot = AXI_PROT;

endmodule

// File: tb/tb_k10_axil_master.sv
// tb/tb_k10_axil_master.sv - self-checking bench for k10_axil_master
module tb_k10_axil_master;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic        i_req_we = 1'b0;
  logic [31:0] i_req_addr = '0;
  logic [31:0] i_req_wdata = '0;
  logic [3:0]  i_req_be = '0;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic        o_busy;
  logic [31:0] m_axi_awaddr;
  logic [2:0]  m_axi_awprot;
  logic        m_axi_awvalid;
  logic        m_axi_awready = 1'b0;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wvalid;
  logic        m_axi_wready = 1'b0;
  logic [1:0]  m_axi_bresp = '0;
  logic        m_axi_bvalid = 1'b0;
  logic        m_axi_bready;
  logic [31:0] m_axi_araddr;
  logic [2:0]  m_axi_arprot;
  logic        m_axi_arvalid;
  logic        m_axi_arready = 1'b0;
  logic [31:0] m_axi_rdata = '0;
  logic [1:0]  m_axi_rresp = '0;
  logic        m_axi_rvalid = 1'b0;
  logic        m_axi_rready;

  k10_axil_master dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_we(i_req_we),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata), .i_req_be(i_req_be),
    .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err), .o_busy(o_busy),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  // Slave behaviour for the current transaction
  int          cfg_aw_dly, cfg_w_dly, cfg_ar_dly, cfg_b_dly, cfg_r_dly;
  logic [1:0]  cfg_resp;
  logic [31:0] cfg_rdata;
  logic        cfg_spur;
  int          aw_wait, w_wait, ar_wait, b_wait, r_wait;

  // Observations
  typedef struct {int cyc; logic [31:0] rdata; logic err;} rsp_t;
  int   acc_q[$];
  rsp_t rsp_q[$];
  int   aw_cycles, w_cycles, ar_cycles;
  int   aw_first_cyc, ar_first_cyc, b_first_cyc, r_first_cyc;
  logic [31:0] aw_first_addr, ar_first_addr, w_first_data;
  logic [3:0]  w_first_strb;

  logic        p_awvalid, p_awready, p_wvalid, p_wready, p_arvalid, p_arready, p_bready, p_rready, p_rsp_valid;
  logic [31:0] p_awaddr, p_wdata, p_araddr, held_rdata;
  logic [3:0]  p_wstrb;
  logic        held_err;

  // Readies/slave-valids are set at the falling edge for the coming rising
  // edge; the monitor runs afterwards so it sees the handshake of this cycle.
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
      m_axi_bvalid = 0; m_axi_rvalid = 0; m_axi_bresp = 0; m_axi_rresp = 0; m_axi_rdata = 0;
      aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
      p_awvalid = 0; p_awready = 0; p_wvalid = 0; p_wready = 0; p_arvalid = 0; p_arready = 0;
      p_bready = 0; p_rready = 0; p_rsp_valid = 0; held_rdata = 0; held_err = 0;
    end else begin
      if (m_axi_awvalid) begin
        if (aw_wait >= cfg_aw_dly) begin m_axi_awready = 1; aw_wait = 0; end
        else begin m_axi_awready = 0; aw_wait++; end
      end else m_axi_awready = 0;
      if (m_axi_wvalid) begin
        if (w_wait >= cfg_w_dly) begin m_axi_wready = 1; w_wait = 0; end
        else begin m_axi_wready = 0; w_wait++; end
      end else m_axi_wready = 0;
      if (m_axi_arvalid) begin
        if (ar_wait >= cfg_ar_dly) begin m_axi_arready = 1; ar_wait = 0; end
        else begin m_axi_arready = 0; ar_wait++; end
      end else m_axi_arready = 0;
      if (m_axi_bready) begin
        if (b_wait >= cfg_b_dly) begin m_axi_bvalid = 1; m_axi_bresp = cfg_resp; b_wait = 0; end
        else begin m_axi_bvalid = 0; b_wait++; end
      end else begin
        m_axi_bvalid = cfg_spur ? 1'($urandom_range(0, 1)) : 1'b0;
        m_axi_bresp  = 2'($urandom);
      end
      if (m_axi_rready) begin
        if (r_wait >= cfg_r_dly) begin
          m_axi_rvalid = 1; m_axi_rresp = cfg_resp; m_axi_rdata = cfg_rdata; r_wait = 0;
        end else begin m_axi_rvalid = 0; r_wait++; end
      end else begin
        m_axi_rvalid = cfg_spur ? 1'($urandom_range(0, 1)) : 1'b0;
        m_axi_rresp  = 2'($urandom);
        m_axi_rdata  = $urandom;
      end

      if (p_awvalid && !p_awready) begin
        n_cmp++;
        if (m_axi_awvalid !== 1'b1 || m_axi_awaddr !== p_awaddr) begin
          n_fail++; $display("FAIL aw_hold cyc=%0d got valid=%b addr=%h need valid=1 addr=%h", cyc, m_axi_awvalid, m_axi_awaddr, p_awaddr);
        end
      end
      if (p_wvalid && !p_wready) begin
        n_cmp++;
        if (m_axi_wvalid !== 1'b1 || m_axi_wdata !== p_wdata || m_axi_wstrb !== p_wstrb) begin
          n_fail++; $display("FAIL w_hold cyc=%0d got valid=%b data=%h strb=%h need valid=1 data=%h strb=%h", cyc, m_axi_wvalid, m_axi_wdata, m_axi_wstrb, p_wdata, p_wstrb);
        end
      end
      if (p_arvalid && !p_arready) begin
        n_cmp++;
        if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== p_araddr) begin
          n_fail++; $display("FAIL ar_hold cyc=%0d got valid=%b addr=%h need valid=1 addr=%h", cyc, m_axi_arvalid, m_axi_araddr, p_araddr);
        end
      end
      n_cmp++;
      if ((m_axi_awvalid || m_axi_wvalid || m_axi_bready) && (m_axi_arvalid || m_axi_rready)) begin
        n_fail++; $display("FAIL overlap cyc=%0d read and write channels active together, need one at most", cyc);
      end
      n_cmp++;
      if (o_busy !== !o_req_ready) begin
        n_fail++; $display("FAIL busy cyc=%0d got busy=%b ready=%b need busy=!ready", cyc, o_busy, o_req_ready);
      end
      if (p_rsp_valid) begin
        n_cmp++;
        if (o_rsp_valid !== 1'b0) begin
          n_fail++; $display("FAIL rsp_pulse cyc=%0d got rsp_valid=%b need 0", cyc, o_rsp_valid);
        end
      end
      if (!o_rsp_valid) begin
        n_cmp++;
        if (o_rsp_rdata !== held_rdata || o_rsp_err !== held_err) begin
          n_fail++; $display("FAIL rsp_hold cyc=%0d got rdata=%h err=%b need rdata=%h err=%b", cyc, o_rsp_rdata, o_rsp_err, held_rdata, held_err);
        end
      end

      if (i_req_valid && o_req_ready) acc_q.push_back(cyc);
      if (o_rsp_valid) begin
        rsp_q.push_back('{cyc, o_rsp_rdata, o_rsp_err});
        held_rdata = o_rsp_rdata; held_err = o_rsp_err;
      end
      if (m_axi_awvalid) begin
        if (!p_awvalid && aw_first_cyc < 0) begin aw_first_cyc = cyc; aw_first_addr = m_axi_awaddr; end
        aw_cycles++;
      end
      if (m_axi_wvalid) begin
        if (!p_wvalid && aw_cycles >= 0 && w_cycles == 0) begin w_first_data = m_axi_wdata; w_first_strb = m_axi_wstrb; end
        w_cycles++;
      end
      if (m_axi_arvalid) begin
        if (!p_arvalid && ar_first_cyc < 0) begin ar_first_cyc = cyc; ar_first_addr = m_axi_araddr; end
        ar_cycles++;
      end
      if (m_axi_bready && !p_bready && b_first_cyc < 0) b_first_cyc = cyc;
      if (m_axi_rready && !p_rready && r_first_cyc < 0) r_first_cyc = cyc;

      p_awvalid = m_axi_awvalid; p_awready = m_axi_awready; p_awaddr = m_axi_awaddr;
      p_wvalid = m_axi_wvalid; p_wready = m_axi_wready; p_wdata = m_axi_wdata; p_wstrb = m_axi_wstrb;
      p_arvalid = m_axi_arvalid; p_arready = m_axi_arready; p_araddr = m_axi_araddr;
      p_bready = m_axi_bready; p_rready = m_axi_rready; p_rsp_valid = o_rsp_valid;
    end
  end

  task automatic set_cfg(input int awd, wd, ard, bd, rdl, input logic [1:0] resp, input logic [31:0] rdata, input logic spur);
    cfg_aw_dly = awd; cfg_w_dly = wd; cfg_ar_dly = ard; cfg_b_dly = bd; cfg_r_dly = rdl;
    cfg_resp = resp; cfg_rdata = rdata; cfg_spur = spur;
    aw_cycles = 0; w_cycles = 0; ar_cycles = 0;
    aw_first_cyc = -1; ar_first_cyc = -1; b_first_cyc = -1; r_first_cyc = -1;
  endtask

  // One complete transaction, checked against latency/payload rules derived
  // from the handshake delays the slave was given.
  task automatic run_txn(input string name, input logic we, input logic [31:0] addr, wdata, input logic [3:0] be,
                         input int awd, wd, ard, bd, rdl, input logic [1:0] resp, input logic [31:0] rdata, input logic spur);
    int n_acc0, n_rsp0, acc, exp_lat;
    bit got;
    rsp_t r;
    set_cfg(awd, wd, ard, bd, rdl, resp, rdata, spur);
    n_acc0 = acc_q.size(); n_rsp0 = rsp_q.size();
    @(posedge i_clk); #1;
    i_req_valid = 1; i_req_we = we; i_req_addr = addr; i_req_wdata = wdata; i_req_be = be;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge i_clk); #1;
      if (acc_q.size() > n_acc0) begin got = 1; break; end
    end
    i_req_valid = 0; i_req_addr = $urandom; i_req_wdata = $urandom;
    n_cmp++;
    if (!got) begin n_fail++; $display("FAIL %s_accept got no acceptance in 20 cycles, need one", name); return; end
    acc = acc_q[n_acc0];
    got = 0;
    for (int i = 0; i < 80; i++) begin
      if (rsp_q.size() > n_rsp0) begin got = 1; break; end
      @(posedge i_clk); #1;
    end
    n_cmp++;
    if (!got) begin n_fail++; $display("FAIL %s_rsp got no response in 80 cycles, need one", name); return; end
    r = rsp_q[n_rsp0];
    exp_lat = we ? 3 + ((awd > wd) ? awd : wd) + bd : 3 + ard + rdl;
    n_cmp++;
    if (r.cyc - acc != exp_lat) begin n_fail++; $display("FAIL %s_latency got %0d need %0d", name, r.cyc - acc, exp_lat); end
    n_cmp++;
    if (r.rdata !== (we ? 32'h0 : rdata) || r.err !== (resp != 2'b00)) begin
      n_fail++; $display("FAIL %s_rsp_data got rdata=%h err=%b need rdata=%h err=%b", name, r.rdata, r.err, we ? 32'h0 : rdata, resp != 2'b00);
    end
    if (we) begin
      n_cmp++;
      if (aw_first_cyc != acc + 1 || aw_first_addr !== addr || w_first_data !== wdata || w_first_strb !== be) begin
        n_fail++; $display("FAIL %s_aw_w got cyc=+%0d addr=%h data=%h strb=%h need cyc=+1 addr=%h data=%h strb=%h",
                           name, aw_first_cyc - acc, aw_first_addr, w_first_data, w_first_strb, addr, wdata, be);
      end
      n_cmp++;
      if (aw_cycles != awd + 1 || w_cycles != wd + 1 || ar_cycles != 0) begin
        n_fail++; $display("FAIL %s_valid_len got aw=%0d w=%0d ar=%0d need aw=%0d w=%0d ar=0", name, aw_cycles, w_cycles, ar_cycles, awd + 1, wd + 1);
      end
      n_cmp++;
      if (b_first_cyc != acc + 2 + ((awd > wd) ? awd : wd)) begin
        n_fail++; $display("FAIL %s_bready got +%0d need +%0d", name, b_first_cyc - acc, 2 + ((awd > wd) ? awd : wd));
      end
    end else begin
      n_cmp++;
      if (ar_first_cyc != acc + 1 || ar_first_addr !== addr || ar_cycles != ard + 1 || aw_cycles != 0 || w_cycles != 0) begin
        n_fail++; $display("FAIL %s_ar got cyc=+%0d addr=%h len=%0d aw=%0d w=%0d need cyc=+1 addr=%h len=%0d aw=0 w=0",
                           name, ar_first_cyc - acc, ar_first_addr, ar_cycles, aw_cycles, w_cycles, addr, ard + 1);
      end
      n_cmp++;
      if (r_first_cyc != acc + 2 + ard) begin
        n_fail++; $display("FAIL %s_rready got +%0d need +%0d", name, r_first_cyc - acc, 2 + ard);
      end
    end
    repeat (3) @(posedge i_clk);
    #1;
    n_cmp++;
    if (rsp_q.size() != n_rsp0 + 1) begin n_fail++; $display("FAIL %s_rsp_count got %0d need 1", name, rsp_q.size() - n_rsp0); end
  endtask

  task automatic test_reset;
    logic [31:0] v;
    repeat (3) @(posedge i_clk);
    #1;
    v = {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready, o_rsp_valid, o_rsp_err, o_busy};
    n_cmp++;
    if (v !== 32'h0 || o_rsp_rdata !== 32'h0 || m_axi_awaddr !== 32'h0 || m_axi_araddr !== 32'h0 ||
        m_axi_wdata !== 32'h0 || m_axi_wstrb !== 4'h0) begin
      n_fail++; $display("FAIL reset_outputs got ctl=%h rdata=%h awaddr=%h araddr=%h wdata=%h wstrb=%h need all 0",
                         v, o_rsp_rdata, m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_wstrb);
    end
    n_cmp++;
    if (m_axi_awprot !== 3'b000 || m_axi_arprot !== 3'b000) begin
      n_fail++; $display("FAIL prot got aw=%b ar=%b need 000", m_axi_awprot, m_axi_arprot);
    end
    i_rst_n = 1;
    @(negedge i_clk);
    n_cmp++;
    if (o_req_ready !== 1'b1 || o_busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_release got ready=%b busy=%b need ready=1 busy=0", o_req_ready, o_busy);
    end
  endtask

  task automatic test_zero_wait_write;
    run_txn("zw_write", 1'b1, 32'h4000_1000, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h0, 1'b0);
  endtask

  task automatic test_skewed_write;
    run_txn("skew_write", 1'b1, 32'h4000_2008, 32'hCAFE_F00D, 4'h6, 0, 4, 0, 1, 0, 2'b00, 32'h0, 1'b0);
  endtask

  task automatic test_read_err;
    run_txn("read_err", 1'b0, 32'h4000_3010, 32'h0, 4'h0, 0, 0, 2, 0, 3, 2'b10, 32'h1234_5678, 1'b0);
  endtask

  task automatic test_back_to_back;
    int n_acc0, n_rsp0;
    bit got;
    logic [31:0] rd, waddr;
    rd = $urandom; waddr = $urandom;
    set_cfg(0, 0, 0, 0, 0, 2'b00, rd, 1'b0);
    n_acc0 = acc_q.size(); n_rsp0 = rsp_q.size();
    @(posedge i_clk); #1;
    i_req_valid = 1; i_req_we = 0; i_req_addr = 32'h5000_0000; i_req_be = 4'h0;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge i_clk); #1;
      if (acc_q.size() == n_acc0 + 1 && i_req_we == 0) begin
        i_req_we = 1; i_req_addr = waddr; i_req_wdata = $urandom; i_req_be = 4'hA;
      end
      if (acc_q.size() >= n_acc0 + 2 && rsp_q.size() >= n_rsp0 + 2) begin got = 1; break; end
      if (acc_q.size() >= n_acc0 + 2) i_req_valid = 0;
    end
    i_req_valid = 0;
    n_cmp++;
    if (!got) begin n_fail++; $display("FAIL b2b_done got acc=%0d rsp=%0d need 2 and 2", acc_q.size() - n_acc0, rsp_q.size() - n_rsp0); return; end
    n_cmp++;
    if (acc_q[n_acc0 + 1] - acc_q[n_acc0] != 3 || acc_q[n_acc0 + 1] != rsp_q[n_rsp0].cyc) begin
      n_fail++; $display("FAIL b2b_spacing got accept gap=%0d rsp1 at +%0d need gap=3 rsp1 at +3",
                         acc_q[n_acc0 + 1] - acc_q[n_acc0], rsp_q[n_rsp0].cyc - acc_q[n_acc0]);
    end
    n_cmp++;
    if (rsp_q[n_rsp0 + 1].cyc - acc_q[n_acc0 + 1] != 3) begin
      n_fail++; $display("FAIL b2b_second got latency %0d need 3", rsp_q[n_rsp0 + 1].cyc - acc_q[n_acc0 + 1]);
    end
    n_cmp++;
    if (rsp_q[n_rsp0].rdata !== rd || rsp_q[n_rsp0 + 1].rdata !== 32'h0 || rsp_q[n_rsp0].err !== 1'b0 ||
        rsp_q[n_rsp0 + 1].err !== 1'b0 || aw_first_addr !== waddr) begin
      n_fail++; $display("FAIL b2b_data got rd=%h wr=%h awaddr=%h need rd=%h wr=0 awaddr=%h",
                         rsp_q[n_rsp0].rdata, rsp_q[n_rsp0 + 1].rdata, aw_first_addr, rd, waddr);
    end
  endtask

  task automatic test_random;
    for (int k = 0; k < 24; k++) begin
      logic we;
      logic [1:0] resp;
      we = 1'($urandom_range(0, 1));
      resp = 2'($urandom);
      run_txn(we ? "rnd_write" : "rnd_read", we, $urandom, $urandom, 4'($urandom),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), resp, $urandom, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid;
    int n_rsp0;
    bit got;
    set_cfg(0, 10, 0, 0, 0, 2'b00, 32'h0, 1'b0);
    n_rsp0 = rsp_q.size();
    @(posedge i_clk); #1;
    i_req_valid = 1; i_req_we = 1; i_req_addr = 32'h4000_4000; i_req_wdata = 32'h1111_2222; i_req_be = 4'hF;
    got = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge i_clk); #1;
      if (m_axi_wvalid) begin got = 1; break; end
    end
    i_req_valid = 0;
    @(posedge i_clk); #1;
    n_cmp++;
    if (!got || m_axi_wvalid !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pending got wvalid=%b need 1", m_axi_wvalid); end
    #2;
    i_rst_n = 0;
    #1;
    n_cmp++;
    if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready, o_rsp_valid, o_busy} !== 7'b0 ||
        m_axi_wdata !== 32'h0 || m_axi_awaddr !== 32'h0 || o_rsp_rdata !== 32'h0) begin
      n_fail++; $display("FAIL rst_mid_async got aw=%b w=%b busy=%b wdata=%h awaddr=%h need all 0",
                         m_axi_awvalid, m_axi_wvalid, o_busy, m_axi_wdata, m_axi_awaddr);
    end
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1;
    @(negedge i_clk);
    n_cmp++;
    if (o_req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready got %b need 1", o_req_ready); end
    repeat (4) @(posedge i_clk);
    #1;
    n_cmp++;
    if (rsp_q.size() != n_rsp0) begin n_fail++; $display("FAIL rst_mid_norsp got %0d pulses need 0", rsp_q.size() - n_rsp0); end
  endtask

  initial begin
    set_cfg(0, 0, 0, 0, 0, 2'b00, 32'h0, 1'b0);
    test_reset;
    test_zero_wait_write;
    test_skewed_write;
    test_read_err;
    test_back_to_back;
    test_random;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no completion by %0t need finish", $time);
    $fatal(1);
  end

endmodule
